// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
// Shared definitions for the round-robin 2:1 mux arbiter:
//   - state_t : FSM state encoding (IDLE=0, G0=1, G1=2)
//   - DEFAULT_MAX_HOLD : default grant hold limit under contention
//   - CNT_W : width of the hold counter
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_HOLD = 4;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/mux2_arbiter_mux.sv
// task2_12
// Combinational 2:1 multiplexer (4 bits wide by default).
// Ports:
//   d0 : data selected when s = 0
//   d1 : data selected when s = 1
//   s  : select
//   y  : selected data
module task2_12 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Round-robin arbiter and sequencer for a shared 2:1 mux. Grants one of two
// requesters at a time, drives the mux select, and registers the selected
// word with a valid flag. Under contention a holder keeps the mux for at
// most MAX_HOLD grant cycles before the other side is served.
//
// Optional feature: define MUX_ARB_LOCK_EN to add lock0/lock1 inputs. While
// the current holder's lock is high, preemption is suppressed.
//
// Handshake: req0/req1 are levels held while service is wanted; a grant is
// visible on gnt0/gnt1 (and s) after the edge that sampled the request, and
// y/y_valid carry the granted source's data one edge after that.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req0, req1     : request levels from source 0 / 1
//   d0, d1         : source data words
//   lock0, lock1   : (MUX_ARB_LOCK_EN only) hold-off of preemption
//   gnt0, gnt1     : registered grants, never both high
//   s              : mux select (0 -> d0, 1 -> d1)
//   y, y_valid     : registered mux output and its valid flag
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
`ifdef MUX_ARB_LOCK_EN
    input  logic             lock0,
    input  logic             lock1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    state_t           nxt;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mux_y;
    logic             hold_lock0;
    logic             hold_lock1;
    logic             at_limit;

`ifdef MUX_ARB_LOCK_EN
    assign hold_lock0 = lock0;
    assign hold_lock1 = lock1;
`else
    assign hold_lock0 = 1'b0;
    assign hold_lock1 = 1'b0;
`endif

    assign at_limit = (cnt == CNT_MAX);

    task2_12 #(.WIDTH(WIDTH)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .s  (s),
        .y  (mux_y)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    nxt = last ? G0 : G1;   // tie goes to the source not served last
                else if (req0)
                    nxt = G0;
                else if (req1)
                    nxt = G1;
            end
            G0: begin
                if (!req0)
                    nxt = req1 ? G1 : IDLE;
                else if (req1 && at_limit && !hold_lock0)
                    nxt = G1;
            end
            G1: begin
                if (!req1)
                    nxt = req0 ? G0 : IDLE;
                else if (req0 && at_limit && !hold_lock1)
                    nxt = G0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            s       <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == G0);
            gnt1  <= (nxt == G1);

            // Select and pointer follow the granted source; s holds in IDLE.
            if (nxt != IDLE) begin
                s    <= (nxt == G1);
                last <= (nxt == G1);
            end

            // Counter restarts on every grant entry and saturates at the limit,
            // so a lock release with a saturated count switches immediately.
            if (nxt == IDLE || nxt != state)
                cnt <= '0;
            else if (!at_limit)
                cnt <= cnt + 1'b1;

            if (state != IDLE) begin
                y       <= mux_y;
                y_valid <= 1'b1;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter
// Self-checking bench for mux2_arbiter: a cycle-level reference model of the
// arbitration rules feeds an expected queue that is compared against the DUT
// every cycle, plus literal checks of directed scenarios and a random phase.
// Build with MUX_ARB_LOCK_EN defined to also exercise the lock inputs.
module tb_mux2_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] d0, d1;
    logic             lock0, lock1;
    logic             gnt0, gnt1, s, y_valid;
    logic [WIDTH-1:0] y;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .d0      (d0),
        .d1      (d1),
`ifdef MUX_ARB_LOCK_EN
        .lock0   (lock0),
        .lock1   (lock1),
`endif
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .s       (s),
        .y       (y),
        .y_valid (y_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, 0 or 1. held: edges elapsed since the current owner was granted.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_last  = 1;
    logic       m_s     = 1'b0;
    logic [3:0] m_y     = '0;
    logic       m_yv    = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_held = 0; m_last = 1;
                m_s = 1'b0; m_y = '0; m_yv = 1'b0;
            end else begin
                int  nxt;
                bit  rq[2];
                bit  lk[2];
                rq[0] = req0; rq[1] = req1;
`ifdef MUX_ARB_LOCK_EN
                lk[0] = lock0; lk[1] = lock1;
`else
                lk[0] = 1'b0; lk[1] = 1'b0;
`endif
                if (m_owner >= 0) begin
                    m_y  = (m_owner == 1) ? d1 : d0;
                    m_yv = 1'b1;
                end else begin
                    m_yv = 1'b0;
                end
                if (m_owner < 0) begin
                    if (rq[0] && rq[1]) nxt = 1 - m_last;
                    else if (rq[0])     nxt = 0;
                    else if (rq[1])     nxt = 1;
                    else                nxt = -1;
                end else begin
                    int o;
                    o = m_owner;
                    if (!rq[o])
                        nxt = rq[1-o] ? 1 - o : -1;
                    else if (rq[1-o] && (m_held + 1 >= MAX_HOLD) && !lk[o])
                        nxt = 1 - o;
                    else
                        nxt = o;
                end
                if (nxt >= 0 && nxt == m_owner) m_held = m_held + 1;
                else                            m_held = 0;
                if (nxt >= 0) begin
                    m_last = nxt;
                    m_s    = (nxt == 1);
                end
                m_owner = nxt;
            end
            exp_q.push_back({m_owner == 0, m_owner == 1, m_s, m_y, m_yv});
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("outputs{gnt0,gnt1,s,y,y_valid}", 32'({gnt0, gnt1, s, y, y_valid}), 32'(e));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [11:0] pat;

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = '0; d1 = '0;
        lock0 = 1'b0; lock1 = 1'b0;

        // Reset with both requesting
        step(1);
        check("reset_gnt", 32'({gnt0, gnt1}), 32'd0);
        step(1);
        check("reset_all", 32'({gnt0, gnt1, s, y, y_valid}), 32'd0);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        // Single requester
        step(1);
        req0 = 1'b1; d0 = 4'hA;
        step(1);
        check("single_gnt", 32'({gnt0, gnt1, s}), 32'b100);
        step(1);
        check("single_y", 32'({y, y_valid}), 32'h15);
        req0 = 1'b0;
        step(1);

        // Contention: last served was 0, so source 1 wins first
        req0 = 1'b1; req1 = 1'b1; d0 = 4'h3; d1 = 4'hC;
        pat = 12'b1111_0000_1111;   // bit i-1: gnt1 after edge i
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check("contend_gnt1", 32'(gnt1), 32'(pat[i-1]));
            check("contend_gnt0", 32'(gnt0), 32'(!pat[i-1]));
            if (i == 6) check("contend_y", 32'(y), 32'h3);
        end

        // Early release from G0 at cnt=1
        step(2);
        check("early_in_g0", 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        step(1);
        check("early_switch", 32'({gnt0, gnt1, s}), 32'b011);
        step(1);
        check("early_y", 32'({y, y_valid}), 32'h19);

        // Idle: y holds
        req1 = 1'b0;
        step(2);
        check("idle_hold", 32'({gnt0, gnt1, y, y_valid}), 32'h18);

        // Mid-grant reset
        req1 = 1'b1; d1 = 4'h5;
        step(2);
        rst = 1'b1;
        step(1);
        check("midreset", 32'({gnt0, gnt1, s, y, y_valid}), 32'd0);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        step(1);
        check("post_reset_tie", 32'({gnt0, gnt1}), 32'b10);

`ifdef MUX_ARB_LOCK_EN
        lock0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("lock_hold", 32'(gnt0), 32'd1);
        end
        lock0 = 1'b0;
        step(1);
        check("lock_release", 32'({gnt0, gnt1}), 32'b01);
`endif

        // Random phase, inputs held for short random runs
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                req0 = ($urandom_range(0, 3) != 0);
                req1 = ($urandom_range(0, 3) != 0);
            end
            d0    = 4'($urandom);
            d1    = 4'($urandom);
            lock0 = ($urandom_range(0, 3) == 0);
            lock1 = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            step(1);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
